cache_req_arb2: RTL and testbench
=================================

Name: cache_req_arb2

Overview:
- Two-requester arbiter sharing one cache over the val/rdy mem_req_4B_t / mem_resp_4B_t interface.
- Sits between two clients (e.g. ifetch and lsu) and the single cache port.
- Round-robin grant with a hold on stalled requests.
- An in-order ID FIFO routes cache responses back to the requester that issued them; the cache returns responses in request order.

Parameters:
- DEPTH, 4, maximum outstanding (accepted, not yet responded) requests; power of two, >=2.
- CNT_W, $clog2(DEPTH+1), width of the in-flight count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- req0_val  in  1  requester 0 request valid.
- req0_rdy  out  1  requester 0 request accepted.
- req0_msg  in  mem_req_4B_t  requester 0 request.
- resp0_val  out  1  response valid to requester 0.
- resp0_rdy  in  1  requester 0 can take a response.
- resp0_msg  out  mem_resp_4B_t  response to requester 0.
- req1_val / req1_rdy / req1_msg / resp1_val / resp1_rdy / resp1_msg: same as port 0, for requester 1.
- cachereq_val  out  1  request to cache.
- cachereq_rdy  in  1  cache accepts request.
- cachereq_msg  out  mem_req_4B_t  forwarded request, passed through unmodified (opaque untouched).
- cacheresp_val  in  1  cache response valid.
- cacheresp_rdy  out  1  arbiter accepts response.
- cacheresp_msg  in  mem_resp_4B_t  cache response.
- inflight  out  CNT_W  current outstanding count.
- err_unexp_resp  out  1  sticky: cacheresp_val seen while FIFO empty.

Behaviour:
- Reset (async, rst low):
  - prio_ptr=0, lock=0, lock_id=0.
  - FIFO empty, inflight=0, err_unexp_resp=0.
  - All val/rdy outputs are 0 while in reset.
- State: prio_ptr (1b, favoured requester), lock (1b), lock_id (1b), ID FIFO (DEPTH x 1b, head/tail pointers with wrap, count).
- Grant (combinational):
  - If lock=1, gnt=lock_id.
  - Else if only one reqN_val, gnt is that requester.
  - Else if both valid, gnt=prio_ptr.
  - Else there is no grant.
- cachereq_val = granted requester's val && !full.
- cachereq_msg = granted requester's msg; when no grant, req0_msg is driven.
- reqN_rdy = (gnt==N) && cachereq_rdy && !full. The non-granted requester sees rdy=0.
- Accept = cachereq_val && cachereq_rdy. On accept:
  - push gnt into FIFO.
  - prio_ptr <= ~gnt.
  - lock <= 0.
- Hold: cachereq_val && !cachereq_rdy sets lock<=1, lock_id<=gnt, so the grant cannot switch mid-stall. Requesters keep val/msg stable while stalled (team val/rdy rule).
- Full: when count==DEPTH, cachereq_val=0 and both reqN_rdy=0. Lock is preserved. A same-cycle pop does not unblock the push; the push waits one cycle.
- Response routing:
  - head = FIFO front.
  - respN_val = cacheresp_val && !empty && head==N.
  - respN_msg = cacheresp_msg.
  - cacheresp_rdy = !empty && resp<head>_rdy.
  - Pop when cacheresp_val && cacheresp_rdy.
  - Latency: zero-cycle combinational pass-through in both directions; no added registers.
- Simultaneous push and pop (not full, not empty): count is unchanged and both pointers advance. Push and pop in the same cycle with the FIFO empty is impossible, because a pop requires non-empty.
- Unexpected response: cacheresp_val with the FIFO empty gives cacheresp_rdy=0, and err_unexp_resp<=1 until reset.
- Head-of-line: a requester whose resp_rdy=0 stalls all responses. This is accepted; no reordering.
- inflight = FIFO count, registered.
- Reset mid-operation clears all state immediately. The cache is reset by the same rst; no in-flight recovery.

Decomposition:
- Shared package (existing mem msg package): mem_req_4B_t, mem_resp_4B_t, VC_MEM_REQ/RESP type constants.
- Add to the package: typedef arb_id_t (1b) and localparam ARB_NREQ=2.
- Sub-module arb_id_fifo: DEPTH x 1b synchronous FIFO with push/pop/full/empty/count, same async active-low reset.

Test Plan:
- Req0 only, 4 reads addr 0,4,8,C, cache always ready → 4 accepts in 4 cycles; 4 responses all on resp0_val; resp1_val never 1; inflight returns to 0.
- Req0 and req1 both valid continuously, cache always ready → grants alternate 0,1,0,1 starting with 0 after reset; responses routed in the same order.
- Both valid, req1 granted, cache holds cachereq_rdy=0 for 3 cycles while req0 also valid → cachereq_msg stays req1's for all 3 cycles; req1 accepted on cycle 4; req0 granted next.
- DEPTH=4, cache accepts 4 writes and returns no response → 5th request sees req*_rdy=0 and inflight=4. One response pops → a new accept is possible the following cycle.
- Response for requester 0 at FIFO head with resp0_rdy=0 for 2 cycles → cacheresp_rdy=0 for those cycles, then the handshake completes; resp1 stays blocked behind it.
- cacheresp_val=1 with the FIFO empty → cacheresp_rdy=0 and err_unexp_resp=1. Assert rst low mid-traffic → all outputs 0 and err cleared.

Source files
------------

// File: rtl/cache_req_arb2_pkg.sv
// rtl/cache_req_arb2_pkg.sv - memory message types and arbiter id types shared by cache_req_arb2
package cache_req_arb2_pkg;

    localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_READ   = 3'd0;
    localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_WRITE  = 3'd1;
    localparam logic [2:0] VC_MEM_RESP_MSG_TYPE_READ  = 3'd0;
    localparam logic [2:0] VC_MEM_RESP_MSG_TYPE_WRITE = 3'd1;

    // 4-byte memory request: type, opaque tag, address, length, write data
    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    // 4-byte memory response: type, opaque tag, test bits, length, read data
    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    // Identifies which requester owns an outstanding cache transaction
    typedef logic arb_id_t;

    localparam int ARB_NREQ = 2;

endpackage

// File: rtl/cache_req_arb2_id_fifo.sv
// rtl/cache_req_arb2_id_fifo.sv - in-order requester-id FIFO for response routing
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   push, push_id       enqueue an id (ignored when full)
//   pop                 dequeue the head (ignored when empty)
//   head_id             id at the front of the queue
//   full, empty, count  occupancy status (count is registered)
module arb_id_fifo
    import cache_req_arb2_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  arb_id_t          push_id,
    input  logic             pop,
    output arb_id_t          head_id,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    arb_id_t          mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_id = mem[head_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[tail_ptr] <= push_id;
                tail_ptr      <= tail_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cache_req_arb2.sv
// rtl/cache_req_arb2.sv - two-requester round-robin arbiter in front of a single cache port
//
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   req{0,1}_val/rdy/msg              client request streams
//   resp{0,1}_val/rdy/msg             client response streams
//   cachereq_val/rdy/msg              forwarded request to the cache
//   cacheresp_val/rdy/msg             response from the cache (in request order)
//   inflight                          outstanding request count
//   err_unexp_resp                    sticky flag: cache response with nothing outstanding
module cache_req_arb2
    import cache_req_arb2_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_val,
    output logic             req0_rdy,
    input  mem_req_4B_t      req0_msg,
    output logic             resp0_val,
    input  logic             resp0_rdy,
    output mem_resp_4B_t     resp0_msg,
    input  logic             req1_val,
    output logic             req1_rdy,
    input  mem_req_4B_t      req1_msg,
    output logic             resp1_val,
    input  logic             resp1_rdy,
    output mem_resp_4B_t     resp1_msg,
    output logic             cachereq_val,
    input  logic             cachereq_rdy,
    output mem_req_4B_t      cachereq_msg,
    input  logic             cacheresp_val,
    output logic             cacheresp_rdy,
    input  mem_resp_4B_t     cacheresp_msg,
    output logic [CNT_W-1:0] inflight,
    output logic             err_unexp_resp
);

    logic                prio_ptr;
    logic                lock;
    arb_id_t             lock_id;
    logic                gnt_vld;
    arb_id_t             gnt;
    logic [ARB_NREQ-1:0] req_val;
    logic [ARB_NREQ-1:0] resp_rdy;
    logic                accept;
    logic                stall;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    arb_id_t             head_id;

    assign req_val  = {req1_val, req0_val};
    assign resp_rdy = {resp1_rdy, resp0_rdy};

    // A stalled request keeps the grant until the cache takes it
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = 1'b0;
        if (lock) begin
            gnt_vld = 1'b1;
            gnt     = lock_id;
        end else if (req0_val && req1_val) begin
            gnt_vld = 1'b1;
            gnt     = prio_ptr;
        end else if (req0_val) begin
            gnt_vld = 1'b1;
            gnt     = 1'b0;
        end else if (req1_val) begin
            gnt_vld = 1'b1;
            gnt     = 1'b1;
        end
    end

    // Outputs are gated by rst so every handshake signal is low during reset
    assign cachereq_val = rst && gnt_vld && req_val[gnt] && !fifo_full;
    assign cachereq_msg = (gnt_vld && gnt) ? req1_msg : req0_msg;
    assign req0_rdy     = rst && gnt_vld && (gnt == 1'b0) && cachereq_rdy && !fifo_full;
    assign req1_rdy     = rst && gnt_vld && (gnt == 1'b1) && cachereq_rdy && !fifo_full;

    assign accept = cachereq_val && cachereq_rdy;
    assign stall  = cachereq_val && !cachereq_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_ptr <= 1'b0;
            lock     <= 1'b0;
            lock_id  <= 1'b0;
        end else if (accept) begin
            prio_ptr <= ~gnt;
            lock     <= 1'b0;
        end else if (stall) begin
            lock     <= 1'b1;
            lock_id  <= gnt;
        end
    end

    // Responses follow request order, so the FIFO head names the owner
    assign resp0_val     = rst && cacheresp_val && !fifo_empty && (head_id == 1'b0);
    assign resp1_val     = rst && cacheresp_val && !fifo_empty && (head_id == 1'b1);
    assign resp0_msg     = cacheresp_msg;
    assign resp1_msg     = cacheresp_msg;
    assign cacheresp_rdy = rst && !fifo_empty && resp_rdy[head_id];
    assign pop           = cacheresp_val && cacheresp_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_unexp_resp <= 1'b0;
        end else if (cacheresp_val && fifo_empty) begin
            err_unexp_resp <= 1'b1;
        end
    end

    arb_id_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .push_id (gnt),
        .pop     (pop),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (inflight)
    );

endmodule

// File: tb/tb_cache_req_arb2.sv
// tb/tb_cache_req_arb2.sv - self-checking bench for cache_req_arb2
module tb_cache_req_arb2;
    import cache_req_arb2_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_val, req0_rdy, resp0_val, resp0_rdy;
    logic             req1_val, req1_rdy, resp1_val, resp1_rdy;
    mem_req_4B_t      req0_msg, req1_msg, cachereq_msg;
    mem_resp_4B_t     resp0_msg, resp1_msg, cacheresp_msg;
    logic             cachereq_val, cachereq_rdy, cacheresp_val, cacheresp_rdy;
    logic [CNT_W-1:0] inflight;
    logic             err_unexp_resp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cache_req_arb2 #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .req0_val       (req0_val),
        .req0_rdy       (req0_rdy),
        .req0_msg       (req0_msg),
        .resp0_val      (resp0_val),
        .resp0_rdy      (resp0_rdy),
        .resp0_msg      (resp0_msg),
        .req1_val       (req1_val),
        .req1_rdy       (req1_rdy),
        .req1_msg       (req1_msg),
        .resp1_val      (resp1_val),
        .resp1_rdy      (resp1_rdy),
        .resp1_msg      (resp1_msg),
        .cachereq_val   (cachereq_val),
        .cachereq_rdy   (cachereq_rdy),
        .cachereq_msg   (cachereq_msg),
        .cacheresp_val  (cacheresp_val),
        .cacheresp_rdy  (cacheresp_rdy),
        .cacheresp_msg  (cacheresp_msg),
        .inflight       (inflight),
        .err_unexp_resp (err_unexp_resp)
    );

    function automatic mem_req_4B_t make_req(input logic id, input logic [6:0] seq);
        mem_req_4B_t m;
        m.msg_type = ($urandom_range(0, 1) == 1) ? VC_MEM_REQ_MSG_TYPE_WRITE : VC_MEM_REQ_MSG_TYPE_READ;
        m.opaque   = {id, seq};
        m.addr     = $urandom & 32'hFFFF_FFFC;
        m.len      = 2'd0;
        m.data     = $urandom;
        return m;
    endfunction

    function automatic mem_resp_4B_t make_resp(input logic [7:0] opaque);
        mem_resp_4B_t r;
        r.msg_type = VC_MEM_RESP_MSG_TYPE_READ;
        r.opaque   = opaque;
        r.test     = 2'd0;
        r.len      = 2'd0;
        r.data     = $urandom;
        return r;
    endfunction

    // Stimulus helpers: inputs change just after a falling edge
    task automatic idle_inputs();
        req0_val = 1'b0; req1_val = 1'b0;
        req0_msg = '0;   req1_msg = '0;
        resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        cachereq_rdy = 1'b0;
        cacheresp_val = 1'b0; cacheresp_msg = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        req0_val = 1'b1; req1_val = 1'b1; cachereq_rdy = 1'b1; cacheresp_val = 1'b1;
        #1;
        n_checks++;
        if ({cachereq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, cacheresp_rdy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: outputs=%b required 000000",
                     {cachereq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, cacheresp_rdy});
        end
        n_checks++;
        if (inflight !== '0 || err_unexp_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: inflight=%0d err=%b required 0 0", inflight, err_unexp_resp);
        end
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_req0_only();
        mem_req_4B_t  m;
        mem_resp_4B_t r;
        do_reset();
        cachereq_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m = make_req(1'b0, 7'(i));
            m.msg_type = VC_MEM_REQ_MSG_TYPE_READ;
            m.addr = 32'(4 * i);
            req0_val = 1'b1; req0_msg = m;
            #1;
            n_checks++;
            if (req0_rdy !== 1'b1 || cachereq_val !== 1'b1 || req1_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL req0_only_accept[%0d]: rdy0=%b val=%b rdy1=%b required 1 1 0", i, req0_rdy, cachereq_val, req1_rdy);
            end
            n_checks++;
            if (cachereq_msg !== m) begin
                n_fail++;
                $display("FAIL req0_only_msg[%0d]: got %h required %h", i, cachereq_msg, m);
            end
            @(negedge clk);
        end
        req0_val = 1'b0;
        #1;
        n_checks++;
        if (inflight !== CNT_W'(4)) begin
            n_fail++;
            $display("FAIL req0_only_inflight4: got %0d required 4", inflight);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            r = make_resp(8'(i));
            cacheresp_val = 1'b1; cacheresp_msg = r;
            #1;
            n_checks++;
            if (resp0_val !== 1'b1 || resp1_val !== 1'b0 || cacheresp_rdy !== 1'b1 || resp0_msg !== r) begin
                n_fail++;
                $display("FAIL req0_only_resp[%0d]: v0=%b v1=%b rdy=%b msg=%h required 1 0 1 %h",
                         i, resp0_val, resp1_val, cacheresp_rdy, resp0_msg, r);
            end
            @(negedge clk);
        end
        cacheresp_val = 1'b0;
        #1;
        n_checks++;
        if (inflight !== '0) begin
            n_fail++;
            $display("FAIL req0_only_inflight0: got %0d required 0", inflight);
        end
        @(negedge clk);
    endtask

    task automatic test_alternate();
        int exp_id;
        do_reset();
        req0_msg = make_req(1'b0, 7'd1);
        req1_msg = make_req(1'b1, 7'd1);
        req0_val = 1'b1; req1_val = 1'b1; cachereq_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_id = i % 2;
            #1;
            n_checks++;
            if (req0_rdy !== (exp_id == 0) || req1_rdy !== (exp_id == 1) ||
                cachereq_msg !== ((exp_id == 1) ? req1_msg : req0_msg)) begin
                n_fail++;
                $display("FAIL alternate_grant[%0d]: rdy0=%b rdy1=%b msg=%h required grant %0d", i, req0_rdy, req1_rdy, cachereq_msg, exp_id);
            end
            @(negedge clk);
        end
        req0_val = 1'b0; req1_val = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_id = i % 2;
            cacheresp_val = 1'b1; cacheresp_msg = make_resp(8'(i));
            #1;
            n_checks++;
            if (resp0_val !== (exp_id == 0) || resp1_val !== (exp_id == 1)) begin
                n_fail++;
                $display("FAIL alternate_route[%0d]: v0=%b v1=%b required owner %0d", i, resp0_val, resp1_val, exp_id);
            end
            @(negedge clk);
        end
        cacheresp_val = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_hold();
        mem_req_4B_t m0, m1;
        do_reset();
        m0 = make_req(1'b0, 7'd2);
        m1 = make_req(1'b1, 7'd2);
        req0_val = 1'b1; req0_msg = m0; cachereq_rdy = 1'b1;
        @(negedge clk);
        req1_val = 1'b1; req1_msg = m1; cachereq_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (cachereq_val !== 1'b1 || cachereq_msg !== m1 || req0_rdy !== 1'b0 || req1_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stall[%0d]: val=%b msg=%h rdy0=%b rdy1=%b required 1 %h 0 0",
                         i, cachereq_val, cachereq_msg, req0_rdy, req1_rdy, m1);
            end
            @(negedge clk);
        end
        cachereq_rdy = 1'b1;
        #1;
        n_checks++;
        if (req1_rdy !== 1'b1 || cachereq_msg !== m1) begin
            n_fail++;
            $display("FAIL hold_release: rdy1=%b msg=%h required 1 %h", req1_rdy, cachereq_msg, m1);
        end
        @(negedge clk);
        req1_val = 1'b0;
        #1;
        n_checks++;
        if (req0_rdy !== 1'b1 || cachereq_msg !== m0) begin
            n_fail++;
            $display("FAIL hold_next: rdy0=%b msg=%h required 1 %h", req0_rdy, cachereq_msg, m0);
        end
        @(negedge clk);
        req0_val = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        cachereq_rdy = 1'b1; req0_val = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            req0_msg = make_req(1'b0, 7'(i));
            req0_msg.msg_type = VC_MEM_REQ_MSG_TYPE_WRITE;
            @(negedge clk);
        end
        req0_msg = make_req(1'b0, 7'd9);
        #1;
        n_checks++;
        if (req0_rdy !== 1'b0 || req1_rdy !== 1'b0 || cachereq_val !== 1'b0 || inflight !== CNT_W'(DEPTH)) begin
            n_fail++;
            $display("FAIL full_block: rdy0=%b rdy1=%b val=%b inflight=%0d required 0 0 0 %0d",
                     req0_rdy, req1_rdy, cachereq_val, inflight, DEPTH);
        end
        @(negedge clk);
        cacheresp_val = 1'b1; cacheresp_msg = make_resp(8'd0);
        #1;
        n_checks++;
        if (cachereq_val !== 1'b0 || cacheresp_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL full_same_cycle_pop: val=%b resp_rdy=%b required 0 1", cachereq_val, cacheresp_rdy);
        end
        @(negedge clk);
        cacheresp_val = 1'b0;
        #1;
        n_checks++;
        if (cachereq_val !== 1'b1 || req0_rdy !== 1'b1 || inflight !== CNT_W'(DEPTH - 1)) begin
            n_fail++;
            $display("FAIL full_unblock: val=%b rdy0=%b inflight=%0d required 1 1 %0d", cachereq_val, req0_rdy, inflight, DEPTH - 1);
        end
        @(negedge clk);
        req0_val = 1'b0;
    endtask

    task automatic test_hol();
        do_reset();
        req0_val = 1'b1; req1_val = 1'b1; cachereq_rdy = 1'b1;
        req0_msg = make_req(1'b0, 7'd3); req1_msg = make_req(1'b1, 7'd3);
        @(negedge clk);
        @(negedge clk);
        req0_val = 1'b0; req1_val = 1'b0;
        resp0_rdy = 1'b0; resp1_rdy = 1'b1;
        cacheresp_val = 1'b1; cacheresp_msg = make_resp(8'h03);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (cacheresp_rdy !== 1'b0 || resp0_val !== 1'b1 || resp1_val !== 1'b0) begin
                n_fail++;
                $display("FAIL hol_block[%0d]: rdy=%b v0=%b v1=%b required 0 1 0", i, cacheresp_rdy, resp0_val, resp1_val);
            end
            @(negedge clk);
        end
        resp0_rdy = 1'b1;
        #1;
        n_checks++;
        if (cacheresp_rdy !== 1'b1 || resp0_val !== 1'b1) begin
            n_fail++;
            $display("FAIL hol_release: rdy=%b v0=%b required 1 1", cacheresp_rdy, resp0_val);
        end
        @(negedge clk);
        cacheresp_msg = make_resp(8'h83);
        #1;
        n_checks++;
        if (cacheresp_rdy !== 1'b1 || resp1_val !== 1'b1 || resp0_val !== 1'b0 || resp1_msg !== cacheresp_msg) begin
            n_fail++;
            $display("FAIL hol_second: rdy=%b v0=%b v1=%b required 1 0 1", cacheresp_rdy, resp0_val, resp1_val);
        end
        @(negedge clk);
        cacheresp_val = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unexp_and_reset();
        do_reset();
        cacheresp_val = 1'b1; cacheresp_msg = make_resp(8'h55);
        #1;
        n_checks++;
        if (cacheresp_rdy !== 1'b0 || resp0_val !== 1'b0 || resp1_val !== 1'b0) begin
            n_fail++;
            $display("FAIL unexp_rdy: rdy=%b v0=%b v1=%b required 0 0 0", cacheresp_rdy, resp0_val, resp1_val);
        end
        @(negedge clk);
        cacheresp_val = 1'b0;
        req0_val = 1'b1; req0_msg = make_req(1'b0, 7'd5); cachereq_rdy = 1'b1;
        #1;
        n_checks++;
        if (err_unexp_resp !== 1'b1) begin
            n_fail++;
            $display("FAIL unexp_err: got %b required 1", err_unexp_resp);
        end
        @(negedge clk);
        cacheresp_val = 1'b1;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({cachereq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, cacheresp_rdy} !== 6'b0 ||
            err_unexp_resp !== 1'b0 || inflight !== '0) begin
            n_fail++;
            $display("FAIL midreset: outs=%b err=%b inflight=%0d required 000000 0 0",
                     {cachereq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, cacheresp_rdy}, err_unexp_resp, inflight);
        end
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Reference: queue of owners in issue order, favoured requester, and the
    // requester currently shown to the cache but not yet taken (-1 if none)
    task automatic test_random();
        int          owner_q[$];
        int          favoured, held, g, head, nfail0;
        logic        v[2];
        logic        keep[2];
        mem_req_4B_t m[2];
        logic        rr[2];
        logic        crdy, cval_exp, full;
        logic [6:0]  seq;
        do_reset();
        favoured = 0; held = -1; seq = '0;
        keep[0] = 1'b0; keep[1] = 1'b0;
        m[0] = '0; m[1] = '0;
        nfail0 = n_fail;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int n = 0; n < 2; n++) begin
                if (!keep[n]) begin
                    v[n] = ($urandom_range(0, 2) != 0);
                    seq  = seq + 7'd1;
                    m[n] = make_req(n[0], seq);
                end
                rr[n] = ($urandom_range(0, 3) != 0);
            end
            crdy = ($urandom_range(0, 3) != 0);
            req0_val = v[0]; req0_msg = m[0]; req1_val = v[1]; req1_msg = m[1];
            resp0_rdy = rr[0]; resp1_rdy = rr[1]; cachereq_rdy = crdy;
            cacheresp_val = (owner_q.size() > 0) && ($urandom_range(0, 2) != 0);
            cacheresp_msg = make_resp(8'($urandom));
            #1;
            if (held >= 0) g = held;
            else if (v[0] && v[1]) g = favoured;
            else if (v[0]) g = 0;
            else if (v[1]) g = 1;
            else g = -1;
            full = (owner_q.size() == DEPTH);
            cval_exp = (g >= 0) && v[g] && !full;
            head = (owner_q.size() > 0) ? owner_q[0] : -1;
            n_checks++;
            if (cachereq_val !== cval_exp || req0_rdy !== (g == 0 && crdy && !full) || req1_rdy !== (g == 1 && crdy && !full)) begin
                n_fail++;
                $display("FAIL rand_req[%0d]: val=%b rdy0=%b rdy1=%b required val=%b grant=%0d full=%b",
                         cyc, cachereq_val, req0_rdy, req1_rdy, cval_exp, g, full);
            end
            n_checks++;
            if (cval_exp && cachereq_msg !== m[g]) begin
                n_fail++;
                $display("FAIL rand_msg[%0d]: got %h required %h", cyc, cachereq_msg, m[g]);
            end
            n_checks++;
            if (resp0_val !== (cacheresp_val && head == 0) || resp1_val !== (cacheresp_val && head == 1) ||
                cacheresp_rdy !== (head >= 0 && rr[head == 1])) begin
                n_fail++;
                $display("FAIL rand_resp[%0d]: v0=%b v1=%b rdy=%b required head=%0d",
                         cyc, resp0_val, resp1_val, cacheresp_rdy, head);
            end
            n_checks++;
            if (inflight !== CNT_W'(owner_q.size()) || resp0_msg !== cacheresp_msg || resp1_msg !== cacheresp_msg) begin
                n_fail++;
                $display("FAIL rand_inflight[%0d]: got %0d required %0d", cyc, inflight, owner_q.size());
            end
            // advance the reference
            keep[0] = v[0]; keep[1] = v[1];
            if (cval_exp && crdy) begin
                owner_q.push_back(g);
                favoured = 1 - g;
                held = -1;
                keep[g] = 1'b0;
            end else if (cval_exp) begin
                held = g;
            end
            if (cacheresp_val && head >= 0 && rr[head == 1]) begin
                void'(owner_q.pop_front());
            end
            @(negedge clk);
            if (n_fail - nfail0 > 20) break;
        end
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_req0_only();
        test_alternate();
        test_hold();
        test_full();
        test_hol();
        test_unexp_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
